// File: rtl/reorder_buffer.sv
// Per-thread reorder buffer: in-order dispatch of up to two entries per cycle, out-of-order
// completion from two CDB ports, and in-order retirement of up to two entries per cycle.
module reorder_buffer #(
   parameter int ROB_SIZE = 32,
   parameter int ROB_BITS = 5,
   parameter int PRN_BITS = 7,
   parameter int ARN_BITS = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                dispatch_0,
   input  logic                dispatch_1,
   input  logic [ARN_BITS-1:0] ARN_dest_0,
   input  logic [ARN_BITS-1:0] ARN_dest_1,
   input  logic [PRN_BITS-1:0] PRN_dest_0,
   input  logic [PRN_BITS-1:0] PRN_dest_1,
   input  logic [63:0]         pc_0,
   input  logic [63:0]         pc_1,
   input  logic                is_branch_0,
   input  logic                is_branch_1,
   input  logic                is_halt_0,
   input  logic                is_halt_1,
   input  logic                cdb_valid_0,
   input  logic                cdb_valid_1,
   input  logic [ROB_BITS-1:0] cdb_ROB_idx_0,
   input  logic [ROB_BITS-1:0] cdb_ROB_idx_1,
   input  logic                cdb_mispredict_0,
   input  logic                cdb_mispredict_1,
   input  logic [63:0]         cdb_target_0,
   input  logic [63:0]         cdb_target_1,
   output logic [ROB_BITS-1:0] ROB_tail,
   output logic                ROB_full,
   output logic                ROB_almost_full,
   output logic                retire_valid_0,
   output logic                retire_valid_1,
   output logic [ARN_BITS-1:0] retire_ARN_0,
   output logic [ARN_BITS-1:0] retire_ARN_1,
   output logic [PRN_BITS-1:0] retire_PRN_0,
   output logic [PRN_BITS-1:0] retire_PRN_1,
   output logic                mispredict,
   output logic [63:0]         mispredict_target,
   output logic                halted
);

   localparam logic [ROB_BITS:0]   FULL_COUNT   = (ROB_BITS+1)'(ROB_SIZE);
   localparam logic [ROB_BITS:0]   ALMOST_COUNT = (ROB_BITS+1)'(ROB_SIZE - 1);
   localparam logic [ROB_BITS:0]   CNT_ONE      = (ROB_BITS+1)'(1);
   localparam logic [ROB_BITS:0]   CNT_TWO      = (ROB_BITS+1)'(2);
   localparam logic [ROB_BITS-1:0] IDX_ONE      = ROB_BITS'(1);

   logic [ROB_BITS-1:0] head_q, head_d, tail_q, tail_d;
   logic [ROB_BITS:0]   count_q, count_d;
   logic                halted_q, halted_d;
   logic [ROB_SIZE-1:0] valid_q, valid_d, complete_q, complete_d;

   logic [ROB_SIZE-1:0] isBranch_q, isHalt_q, misp_q;
   logic [ARN_BITS-1:0] arn_q    [ROB_SIZE];
   logic [PRN_BITS-1:0] prn_q    [ROB_SIZE];
   logic [63:0]         pc_q     [ROB_SIZE];
   logic [63:0]         target_q [ROB_SIZE];

   logic [ROB_BITS-1:0] headPlus1, tailPlus1;
   logic                retireValid0, retireValid1, headMisp, doFlush;
   logic [ROB_BITS:0]   nRet, nDisp, freeSlots;
   logic                wrTail, wrNext, srcSel1;
   logic                unusedPc;

   assign headPlus1 = head_q + IDX_ONE;
   assign tailPlus1 = tail_q + IDX_ONE;

   // Mispredicted branches and HALTs only ever retire from the head slot so their side
   // effects (flush / halt) are taken from a single place.
   assign headMisp     = isBranch_q[head_q] & misp_q[head_q];
   assign retireValid0 = valid_q[head_q] & complete_q[head_q] & !halted_q;
   assign retireValid1 = retireValid0 & valid_q[headPlus1] & complete_q[headPlus1]
                         & !headMisp & !isHalt_q[head_q]
                         & !isHalt_q[headPlus1]
                         & !(isBranch_q[headPlus1] & misp_q[headPlus1]);
   assign doFlush      = retireValid0 & headMisp;

   assign nRet      = (ROB_BITS+1)'(retireValid0) + (ROB_BITS+1)'(retireValid1);
   assign nDisp     = (ROB_BITS+1)'(wrTail) + (ROB_BITS+1)'(wrNext);
   assign freeSlots = FULL_COUNT - (count_q - nRet);

   // Slots freed by this cycle's retirement are already available to this cycle's dispatch.
   always_comb begin
      wrTail  = 1'b0;
      wrNext  = 1'b0;
      srcSel1 = 1'b0;
      if (!doFlush) begin
         if (dispatch_0 && dispatch_1) begin
            wrTail = (freeSlots >= CNT_ONE);
            wrNext = (freeSlots >= CNT_TWO);
         end else if (dispatch_0 || dispatch_1) begin
            wrTail  = (freeSlots >= CNT_ONE);
            srcSel1 = dispatch_1;
         end
      end
   end

   // Update order matters: completion, then retirement, then dispatch (a full buffer may
   // re-fill the head slot it is retiring), with a mispredict flush overriding everything.
   always_comb begin
      valid_d    = valid_q;
      complete_d = complete_q;
      head_d     = head_q + nRet[ROB_BITS-1:0];
      tail_d     = tail_q + nDisp[ROB_BITS-1:0];
      count_d    = count_q + nDisp - nRet;
      halted_d   = halted_q | (retireValid0 & isHalt_q[head_q]);
      if (cdb_valid_1 && valid_q[cdb_ROB_idx_1]) complete_d[cdb_ROB_idx_1] = 1'b1;
      if (cdb_valid_0 && valid_q[cdb_ROB_idx_0]) complete_d[cdb_ROB_idx_0] = 1'b1;
      if (retireValid0) begin
         valid_d[head_q]    = 1'b0;
         complete_d[head_q] = 1'b0;
      end
      if (retireValid1) begin
         valid_d[headPlus1]    = 1'b0;
         complete_d[headPlus1] = 1'b0;
      end
      if (wrTail) begin
         valid_d[tail_q]    = 1'b1;
         complete_d[tail_q] = 1'b0;
      end
      if (wrNext) begin
         valid_d[tailPlus1]    = 1'b1;
         complete_d[tailPlus1] = 1'b0;
      end
      if (doFlush) begin
         valid_d    = '0;
         complete_d = '0;
         head_d     = headPlus1;
         tail_d     = headPlus1;
         count_d    = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         halted_q   <= 1'b0;
         valid_q    <= '0;
         complete_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         halted_q   <= halted_d;
         valid_q    <= valid_d;
         complete_q <= complete_d;
      end
   end

   // Payload needs no reset: it is only observed through valid entries. Port 0 is written
   // last so it wins a same-index collision.
   always_ff @(posedge clock) begin
      if (cdb_valid_1 && valid_q[cdb_ROB_idx_1]) begin
         misp_q[cdb_ROB_idx_1]   <= cdb_mispredict_1;
         target_q[cdb_ROB_idx_1] <= cdb_target_1;
      end
      if (cdb_valid_0 && valid_q[cdb_ROB_idx_0]) begin
         misp_q[cdb_ROB_idx_0]   <= cdb_mispredict_0;
         target_q[cdb_ROB_idx_0] <= cdb_target_0;
      end
      if (wrTail) begin
         arn_q[tail_q]      <= srcSel1 ? ARN_dest_1 : ARN_dest_0;
         prn_q[tail_q]      <= srcSel1 ? PRN_dest_1 : PRN_dest_0;
         pc_q[tail_q]       <= srcSel1 ? pc_1 : pc_0;
         isBranch_q[tail_q] <= srcSel1 ? is_branch_1 : is_branch_0;
         isHalt_q[tail_q]   <= srcSel1 ? is_halt_1 : is_halt_0;
         misp_q[tail_q]     <= 1'b0;
      end
      if (wrNext) begin
         arn_q[tailPlus1]      <= ARN_dest_1;
         prn_q[tailPlus1]      <= PRN_dest_1;
         pc_q[tailPlus1]       <= pc_1;
         isBranch_q[tailPlus1] <= is_branch_1;
         isHalt_q[tailPlus1]   <= is_halt_1;
         misp_q[tailPlus1]     <= 1'b0;
      end
   end

   assign unusedPc = ^pc_q[head_q];

   assign ROB_tail          = reset ? '0 : tail_q;
   assign ROB_full          = !reset & (count_q == FULL_COUNT);
   assign ROB_almost_full   = !reset & (count_q == ALMOST_COUNT);
   assign retire_valid_0    = !reset & retireValid0;
   assign retire_valid_1    = !reset & retireValid1;
   assign retire_ARN_0      = retire_valid_0 ? arn_q[head_q] : '0;
   assign retire_PRN_0      = retire_valid_0 ? prn_q[head_q] : '0;
   assign retire_ARN_1      = retire_valid_1 ? arn_q[headPlus1] : '0;
   assign retire_PRN_1      = retire_valid_1 ? prn_q[headPlus1] : '0;
   assign mispredict        = !reset & doFlush;
   assign mispredict_target = mispredict ? target_q[head_q] : '0;
   assign halted            = !reset & halted_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, table-driven bench for reorder_buffer: each record holds one cycle of stimulus
// and the outputs expected from the state left by all earlier records.
module tb_reorder_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        dispatch_0, dispatch_1;
   logic [4:0]  ARN_dest_0, ARN_dest_1;
   logic [6:0]  PRN_dest_0, PRN_dest_1;
   logic [63:0] pc_0, pc_1;
   logic        is_branch_0, is_branch_1, is_halt_0, is_halt_1;
   logic        cdb_valid_0, cdb_valid_1;
   logic [4:0]  cdb_ROB_idx_0, cdb_ROB_idx_1;
   logic        cdb_mispredict_0, cdb_mispredict_1;
   logic [63:0] cdb_target_0, cdb_target_1;
   logic [4:0]  ROB_tail;
   logic        ROB_full, ROB_almost_full;
   logic        retire_valid_0, retire_valid_1;
   logic [4:0]  retire_ARN_0, retire_ARN_1;
   logic [6:0]  retire_PRN_0, retire_PRN_1;
   logic        mispredict;
   logic [63:0] mispredict_target;
   logic        halted;

   int checks = 0;
   int errors = 0;
   int curIdx = 0;

   reorder_buffer dut (
      .clock(clock), .reset(reset),
      .dispatch_0(dispatch_0), .dispatch_1(dispatch_1),
      .ARN_dest_0(ARN_dest_0), .ARN_dest_1(ARN_dest_1),
      .PRN_dest_0(PRN_dest_0), .PRN_dest_1(PRN_dest_1),
      .pc_0(pc_0), .pc_1(pc_1),
      .is_branch_0(is_branch_0), .is_branch_1(is_branch_1),
      .is_halt_0(is_halt_0), .is_halt_1(is_halt_1),
      .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1),
      .cdb_ROB_idx_0(cdb_ROB_idx_0), .cdb_ROB_idx_1(cdb_ROB_idx_1),
      .cdb_mispredict_0(cdb_mispredict_0), .cdb_mispredict_1(cdb_mispredict_1),
      .cdb_target_0(cdb_target_0), .cdb_target_1(cdb_target_1),
      .ROB_tail(ROB_tail), .ROB_full(ROB_full), .ROB_almost_full(ROB_almost_full),
      .retire_valid_0(retire_valid_0), .retire_valid_1(retire_valid_1),
      .retire_ARN_0(retire_ARN_0), .retire_ARN_1(retire_ARN_1),
      .retire_PRN_0(retire_PRN_0), .retire_PRN_1(retire_PRN_1),
      .mispredict(mispredict), .mispredict_target(mispredict_target),
      .halted(halted)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        d0, d1, br0, br1, ht0, ht1;
      logic [4:0]  arn0, arn1;
      logic [6:0]  prn0, prn1;
      logic        c0, c1, cm0, cm1;
      logic [4:0]  ci0, ci1;
      logic [63:0] ct0, ct1;
      logic        eRv0, eRv1, eMisp, eFull, eAfull, eHalt;
      logic [6:0]  ePrn0, ePrn1;
      logic [63:0] eTgt;
      logic [4:0]  eTail;
   } vecT;

   vecT tbl[$];

   function automatic vecT base(input logic [4:0] tail);
      vecT v;
      v = '{default: '0};
      v.eTail = tail;
      return v;
   endfunction

   // ARN is derived from the PRN so retire checks cover both fields with one number.
   function automatic vecT withDisp(input vecT vin, input logic s0, input logic s1,
                                    input logic [6:0] p0, input logic [6:0] p1,
                                    input logic br, input logic ht);
      vecT v;
      v = vin;
      v.d0 = s0; v.d1 = s1;
      v.prn0 = p0; v.arn0 = p0[4:0];
      v.prn1 = p1; v.arn1 = p1[4:0];
      v.br0 = br; v.ht0 = ht;
      return v;
   endfunction

   function automatic vecT withCdb(input vecT vin, input int port, input logic [4:0] idx,
                                   input logic mp, input logic [63:0] tgt);
      vecT v;
      v = vin;
      if (port == 0) begin
         v.c0 = 1'b1; v.ci0 = idx; v.cm0 = mp; v.ct0 = tgt;
      end else begin
         v.c1 = 1'b1; v.ci1 = idx; v.cm1 = mp; v.ct1 = tgt;
      end
      return v;
   endfunction

   function automatic vecT withRet(input vecT vin, input logic r0, input logic r1,
                                   input logic [6:0] p0, input logic [6:0] p1);
      vecT v;
      v = vin;
      v.eRv0 = r0; v.eRv1 = r1; v.ePrn0 = p0; v.ePrn1 = p1;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s vector %0d: got 0x%0h expected 0x%0h", name, curIdx, act, exp);
      end
   endtask

   task automatic checkOutput(input vecT v);
      checkVal("retire_valid_0", 64'(retire_valid_0), 64'(v.eRv0));
      checkVal("retire_valid_1", 64'(retire_valid_1), 64'(v.eRv1));
      if (v.eRv0) begin
         checkVal("retire_PRN_0", 64'(retire_PRN_0), 64'(v.ePrn0));
         checkVal("retire_ARN_0", 64'(retire_ARN_0), 64'(v.ePrn0[4:0]));
      end
      if (v.eRv1) begin
         checkVal("retire_PRN_1", 64'(retire_PRN_1), 64'(v.ePrn1));
         checkVal("retire_ARN_1", 64'(retire_ARN_1), 64'(v.ePrn1[4:0]));
      end
      checkVal("mispredict", 64'(mispredict), 64'(v.eMisp));
      if (v.eMisp) checkVal("mispredict_target", mispredict_target, v.eTgt);
      checkVal("ROB_tail", 64'(ROB_tail), 64'(v.eTail));
      checkVal("ROB_full", 64'(ROB_full), 64'(v.eFull));
      checkVal("ROB_almost_full", 64'(ROB_almost_full), 64'(v.eAfull));
      checkVal("halted", 64'(halted), 64'(v.eHalt));
   endtask

   task automatic applyStimulus(input vecT v);
      reset            = v.rst;
      dispatch_0       = v.d0;           dispatch_1       = v.d1;
      ARN_dest_0       = v.arn0;         ARN_dest_1       = v.arn1;
      PRN_dest_0       = v.prn0;         PRN_dest_1       = v.prn1;
      pc_0             = {57'd0, v.prn0}; pc_1            = {57'd0, v.prn1};
      is_branch_0      = v.br0;          is_branch_1      = v.br1;
      is_halt_0        = v.ht0;          is_halt_1        = v.ht1;
      cdb_valid_0      = v.c0;           cdb_valid_1      = v.c1;
      cdb_ROB_idx_0    = v.ci0;          cdb_ROB_idx_1    = v.ci1;
      cdb_mispredict_0 = v.cm0;          cdb_mispredict_1 = v.cm1;
      cdb_target_0     = v.ct0;          cdb_target_1     = v.ct1;
   endtask

   task automatic runVec(input vecT v);
      @(negedge clock);
      checkOutput(v);
      applyStimulus(v);
      curIdx++;
   endtask

   initial begin
      vecT v;
      v = base(5'd0);
      v.rst = 1'b1;
      applyStimulus(v);

      // Basic dual dispatch, out-of-order completion, dual retire
      tbl.push_back(withDisp(base(5'd0), 1'b1, 1'b1, 7'd10, 7'd11, 1'b0, 1'b0));
      tbl.push_back(withDisp(base(5'd2), 1'b1, 1'b1, 7'd12, 7'd13, 1'b0, 1'b0));
      tbl.push_back(withCdb(base(5'd4), 0, 5'd1, 1'b0, 64'd0));
      tbl.push_back(withCdb(base(5'd4), 0, 5'd0, 1'b0, 64'd0));
      tbl.push_back(withRet(base(5'd4), 1'b1, 1'b1, 7'd10, 7'd11));
      tbl.push_back(withCdb(withCdb(base(5'd4), 0, 5'd2, 1'b0, 64'd0), 1, 5'd3, 1'b0, 64'd0));
      tbl.push_back(withRet(base(5'd4), 1'b1, 1'b1, 7'd12, 7'd13));
      v = base(5'd4); v.rst = 1'b1; tbl.push_back(v);

      // Mispredicted branch at idx 2 with younger entries 3..5 behind it
      tbl.push_back(withDisp(base(5'd0), 1'b1, 1'b1, 7'd20, 7'd21, 1'b0, 1'b0));
      v = withDisp(base(5'd2), 1'b1, 1'b1, 7'd22, 7'd23, 1'b1, 1'b0);
      tbl.push_back(withCdb(withCdb(v, 0, 5'd0, 1'b0, 64'd0), 1, 5'd1, 1'b0, 64'd0));
      v = withDisp(withRet(base(5'd4), 1'b1, 1'b1, 7'd20, 7'd21), 1'b1, 1'b1, 7'd24, 7'd25, 1'b0, 1'b0);
      tbl.push_back(withCdb(withCdb(v, 0, 5'd2, 1'b1, 64'h1000), 1, 5'd3, 1'b0, 64'd0));
      v = withDisp(withRet(base(5'd6), 1'b1, 1'b0, 7'd22, 7'd0), 1'b1, 1'b0, 7'd26, 7'd0, 1'b0, 1'b0);
      v.eMisp = 1'b1; v.eTgt = 64'h1000; tbl.push_back(v);
      // Post-flush: head = tail = 3; CDB to stale idx 5 is ignored; CDB port collision on idx 3
      v = withDisp(base(5'd3), 1'b1, 1'b0, 7'd27, 7'd0, 1'b1, 1'b0);
      tbl.push_back(withCdb(v, 0, 5'd5, 1'b1, 64'h3000));
      v = withDisp(base(5'd4), 1'b1, 1'b1, 7'd28, 7'd29, 1'b0, 1'b0);
      tbl.push_back(withCdb(withCdb(v, 0, 5'd3, 1'b0, 64'd0), 1, 5'd3, 1'b1, 64'h2000));
      v = withRet(base(5'd6), 1'b1, 1'b0, 7'd27, 7'd0);
      tbl.push_back(withCdb(withCdb(v, 0, 5'd4, 1'b0, 64'd0), 1, 5'd5, 1'b0, 64'd0));
      tbl.push_back(withRet(base(5'd6), 1'b1, 1'b1, 7'd28, 7'd29));
      v = base(5'd6); v.rst = 1'b1; tbl.push_back(v);

      // HALT at head with a completed younger entry behind it
      tbl.push_back(withDisp(base(5'd0), 1'b1, 1'b1, 7'd30, 7'd31, 1'b0, 1'b1));
      tbl.push_back(withCdb(withCdb(base(5'd2), 0, 5'd0, 1'b0, 64'd0), 1, 5'd1, 1'b0, 64'd0));
      tbl.push_back(withRet(base(5'd2), 1'b1, 1'b0, 7'd30, 7'd0));
      v = withDisp(base(5'd2), 1'b1, 1'b0, 7'd32, 7'd0, 1'b0, 1'b0); v.eHalt = 1'b1; tbl.push_back(v);
      v = withCdb(base(5'd3), 0, 5'd2, 1'b0, 64'd0); v.eHalt = 1'b1; tbl.push_back(v);
      v = base(5'd3); v.eHalt = 1'b1; tbl.push_back(v);
      v = base(5'd3); v.eHalt = 1'b1; v.rst = 1'b1; tbl.push_back(v);

      // Reset with six entries held and a dispatch in flight
      tbl.push_back(withDisp(base(5'd0), 1'b1, 1'b1, 7'd40, 7'd41, 1'b0, 1'b0));
      tbl.push_back(withDisp(base(5'd2), 1'b1, 1'b1, 7'd42, 7'd43, 1'b0, 1'b0));
      v = withDisp(base(5'd4), 1'b1, 1'b1, 7'd44, 7'd45, 1'b0, 1'b0);
      tbl.push_back(withCdb(withCdb(v, 0, 5'd0, 1'b0, 64'd0), 1, 5'd1, 1'b0, 64'd0));
      v = withDisp(withRet(base(5'd6), 1'b1, 1'b1, 7'd40, 7'd41), 1'b1, 1'b1, 7'd46, 7'd47, 1'b0, 1'b0);
      v = withCdb(v, 0, 5'd2, 1'b0, 64'd0); v.rst = 1'b1; tbl.push_back(v);
      tbl.push_back(base(5'd0));
      tbl.push_back(base(5'd0));

      repeat (2) @(posedge clock);
      foreach (tbl[i]) runVec(tbl[i]);

      // Fill to almost-full, then full with tail wrap, drop when full, retire+dispatch at full
      for (int i = 0; i < 15; i++)
         runVec(withDisp(base(5'(2 * i)), 1'b1, 1'b1, 7'(50 + 2 * i), 7'(51 + 2 * i), 1'b0, 1'b0));
      runVec(withDisp(base(5'd30), 1'b1, 1'b0, 7'd80, 7'd0, 1'b0, 1'b0));
      v = withDisp(base(5'd31), 1'b1, 1'b0, 7'd81, 7'd0, 1'b0, 1'b0); v.eAfull = 1'b1; runVec(v);
      v = withDisp(base(5'd0), 1'b1, 1'b0, 7'd90, 7'd0, 1'b0, 1'b0); v.eFull = 1'b1; runVec(v);
      v = withCdb(base(5'd0), 0, 5'd0, 1'b0, 64'd0); v.eFull = 1'b1; runVec(v);
      v = withDisp(withRet(base(5'd0), 1'b1, 1'b0, 7'd50, 7'd0), 1'b1, 1'b0, 7'd91, 7'd0, 1'b0, 1'b0);
      v.eFull = 1'b1; runVec(v);
      v = withCdb(withCdb(base(5'd1), 0, 5'd1, 1'b0, 64'd0), 1, 5'd2, 1'b0, 64'd0);
      v.eFull = 1'b1; runVec(v);
      v = withRet(base(5'd1), 1'b1, 1'b1, 7'd51, 7'd52); v.eFull = 1'b1; runVec(v);
      runVec(base(5'd1));

      @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
